// File: rtl/cpu_pkg.sv
// Shared core constants and the multiplier FSM state encoding.
package cpu_pkg;

  localparam int unsigned REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    MULT_IDLE = 2'd0,
    MULT_BUSY = 2'd1,
    MULT_DONE = 2'd2
  } mult_state_t;

endpackage

// File: rtl/mult_chunk_pp.sv
// Combinational partial product: op_a times one multiplier chunk, shifted into
// position k*CHUNK_W and truncated to the accumulator width.
module mult_chunk_pp #(
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned CHUNK_W = 16,
  parameter int unsigned ACC_W   = 64,
  parameter int unsigned CNT_W   = 2
) (
  input  logic [DATA_W-1:0]  op_a_i,
  input  logic [CHUNK_W-1:0] chunk_i,
  input  logic [CNT_W-1:0]   k_i,
  output logic [ACC_W-1:0]   pp_o
);

  logic [ACC_W-1:0] a_ext;
  logic [ACC_W-1:0] c_ext;
  logic [ACC_W-1:0] prod;

  always_comb begin
    a_ext = ACC_W'(op_a_i);
    c_ext = ACC_W'(chunk_i);
    prod  = a_ext * c_ext;
    pp_o  = prod << (k_i * CHUNK_W);
  end

endmodule

// File: rtl/mult_iter_unit.sv
// Iterative EX-stage multiplier: consumes DATA_W/LATENCY multiplier bits per cycle.
// Define MULT_HIGH_EN to add hi_sel and a 2*DATA_W accumulator for MULHU.
module mult_iter_unit
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned LATENCY    = 4,
  parameter int unsigned REG_ADDR_W = cpu_pkg::REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  start,
  input  logic                  flush,
  input  logic [DATA_W-1:0]     op_a,
  input  logic [DATA_W-1:0]     op_b,
  input  logic [REG_ADDR_W-1:0] rd_in,
`ifdef MULT_HIGH_EN
  input  logic                  hi_sel,
`endif
  output logic                  stall,
  output logic [DATA_W-1:0]     result,
  output logic                  result_valid,
  output logic [REG_ADDR_W-1:0] rd_out
);

  localparam int unsigned CHUNK = DATA_W / LATENCY;
  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
`ifdef MULT_HIGH_EN
  localparam int unsigned ACC_W = 2 * DATA_W;
`else
  localparam int unsigned ACC_W = DATA_W;
`endif
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LATENCY - 1);

  mult_state_t state_q, state_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DATA_W-1:0]     a_q, a_d, b_q, b_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d, rd_out_q, rd_out_d;
  logic [ACC_W-1:0]      acc_q, acc_d;
  logic [DATA_W-1:0]     res_q, res_d;
`ifdef MULT_HIGH_EN
  logic                  hi_q, hi_d;
`endif

  logic [CHUNK-1:0]  chunk;
  logic [ACC_W-1:0]  pp;
  logic [ACC_W-1:0]  acc_sum;
  logic [DATA_W-1:0] res_sel;

  mult_chunk_pp #(
    .DATA_W  (DATA_W),
    .CHUNK_W (CHUNK),
    .ACC_W   (ACC_W),
    .CNT_W   (CNT_W)
  ) u_pp (
    .op_a_i  (a_q),
    .chunk_i (chunk),
    .k_i     (count_q),
    .pp_o    (pp)
  );

  always_comb begin
    chunk   = CHUNK'(b_q >> (count_q * CHUNK));
    acc_sum = acc_q + pp;
`ifdef MULT_HIGH_EN
    res_sel = hi_q ? acc_sum[ACC_W-1:DATA_W] : acc_sum[DATA_W-1:0];
`else
    res_sel = acc_sum;
`endif
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state_q <= MULT_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      MULT_IDLE, MULT_DONE: begin
        if (flush)      state_d = MULT_IDLE;
        else if (start) state_d = MULT_BUSY;
        else            state_d = MULT_IDLE;
      end
      MULT_BUSY: begin
        if (flush)                 state_d = MULT_IDLE;
        else if (count_q == LAST)  state_d = MULT_DONE;
      end
      default: state_d = MULT_IDLE;
    endcase
  end

  // The result register loads on the final BUSY edge so it is stable for the
  // whole DONE cycle; a flush in that cycle leaves the previous result in place.
  always_comb begin
    count_d  = count_q;
    a_d      = a_q;
    b_d      = b_q;
    rd_d     = rd_q;
    acc_d    = acc_q;
    res_d    = res_q;
    rd_out_d = rd_out_q;
`ifdef MULT_HIGH_EN
    hi_d     = hi_q;
`endif
    if (state_q != MULT_BUSY && !flush && start) begin
      a_d     = op_a;
      b_d     = op_b;
      rd_d    = rd_in;
      acc_d   = '0;
      count_d = '0;
`ifdef MULT_HIGH_EN
      hi_d    = hi_sel;
`endif
    end else if (state_q == MULT_BUSY && !flush) begin
      acc_d   = acc_sum;
      count_d = count_q + 1'b1;
      if (count_q == LAST) begin
        res_d    = res_sel;
        rd_out_d = rd_q;
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      count_q  <= '0;
      a_q      <= '0;
      b_q      <= '0;
      rd_q     <= '0;
      acc_q    <= '0;
      res_q    <= '0;
      rd_out_q <= '0;
`ifdef MULT_HIGH_EN
      hi_q     <= 1'b0;
`endif
    end else begin
      count_q  <= count_d;
      a_q      <= a_d;
      b_q      <= b_d;
      rd_q     <= rd_d;
      acc_q    <= acc_d;
      res_q    <= res_d;
      rd_out_q <= rd_out_d;
`ifdef MULT_HIGH_EN
      hi_q     <= hi_d;
`endif
    end
  end

  always_comb begin
    stall        = (start && state_q != MULT_BUSY) || (state_q == MULT_BUSY);
    result_valid = (state_q == MULT_DONE);
    result       = res_q;
    rd_out       = rd_out_q;
  end

endmodule

// File: tb/tb_mult_iter_unit.sv
// Directed bench for mult_iter_unit (DATA_W=64, LATENCY=4); the high-half
// checks are built only when MULT_HIGH_EN is defined.
module tb_mult_iter_unit;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned LAT    = 4;

  logic              clk;
  logic              arst_n;
  logic              start;
  logic              flush;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [4:0]        rd_in;
`ifdef MULT_HIGH_EN
  logic              hi_sel;
`endif
  logic              stall;
  logic [DATA_W-1:0] result;
  logic              result_valid;
  logic [4:0]        rd_out;

  int tests = 0;
  int fails = 0;

  mult_iter_unit #(
    .DATA_W     (DATA_W),
    .LATENCY    (LAT),
    .REG_ADDR_W (5)
  ) dut (
    .clk          (clk),
    .arst_n       (arst_n),
    .start        (start),
    .flush        (flush),
    .op_a         (op_a),
    .op_b         (op_b),
    .rd_in        (rd_in),
`ifdef MULT_HIGH_EN
    .hi_sel       (hi_sel),
`endif
    .stall        (stall),
    .result       (result),
    .result_valid (result_valid),
    .rd_out       (rd_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Drives start with the operands (optionally in the current cycle) and
  // checks stall through the LAT BUSY cycles, ending just before DONE.
  task automatic launch(input logic [63:0] a, input logic [63:0] b,
                        input logic [4:0] rd, input bit same_cycle, input string tag);
    if (!same_cycle) @(negedge clk);
    start = 1'b1;
    op_a  = a;
    op_b  = b;
    rd_in = rd;
    #1 chk({tag, "_stall_T"}, stall, 1'b1);
    for (int unsigned i = 1; i <= LAT; i++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      chk({tag, "_stall_busy"}, stall, 1'b1);
      chk({tag, "_valid_busy"}, result_valid, 1'b0);
    end
  endtask

  task automatic chk_done(input logic [63:0] res, input logic [4:0] rd,
                          input logic exp_stall, input string tag);
    #1;
    chk({tag, "_valid"}, result_valid, 1'b1);
    chk({tag, "_result"}, result, res);
    chk({tag, "_rd"}, rd_out, rd);
    chk({tag, "_stall_done"}, stall, exp_stall);
  endtask

  initial begin
    arst_n = 1'b0;
    start  = 1'b0;
    flush  = 1'b0;
    op_a   = '0;
    op_b   = '0;
    rd_in  = '0;
`ifdef MULT_HIGH_EN
    hi_sel = 1'b0;
`endif
    #2;
    chk("rst_stall", stall, 1'b0);
    chk("rst_result", result, 64'd0);
    chk("rst_valid", result_valid, 1'b0);
    chk("rst_rd", rd_out, 5'd0);
    @(negedge clk);
    arst_n = 1'b1;

    // 1: 3*5 -> 15, rd 7, then result holds and valid drops
    launch(64'd3, 64'd5, 5'd7, 1'b0, "t1");
    @(negedge clk);
    chk_done(64'd15, 5'd7, 1'b0, "t1");
    @(negedge clk);
    #1;
    chk("t1_valid_after", result_valid, 1'b0);
    chk("t1_result_hold", result, 64'd15);
    chk("t1_stall_idle", stall, 1'b0);

    // 2: wrap-around modulo 2^64
    launch(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd3, 1'b0, "t2");
    @(negedge clk);
    chk_done(64'hFFFF_FFFF_FFFF_FFFE, 5'd3, 1'b0, "t2");
    @(negedge clk);
    #1 chk("t2_single_pulse", result_valid, 1'b0);

    // 3: back-to-back, second start in the DONE cycle (stall follows start there)
    launch(64'd6, 64'd7, 5'd1, 1'b0, "t3a");
    @(negedge clk);
    start = 1'b1;
    op_a  = 64'd9;
    op_b  = 64'd9;
    rd_in = 5'd2;
    chk_done(64'd42, 5'd1, 1'b1, "t3a");
    launch(64'd9, 64'd9, 5'd2, 1'b1, "t3b");
    @(negedge clk);
    chk_done(64'd81, 5'd2, 1'b0, "t3b");

    // 4: flush at T+2 aborts; previous result kept; no pulse afterwards
    @(negedge clk);
    start = 1'b1;
    op_a  = 64'd10;
    op_b  = 64'd10;
    rd_in = 5'd6;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    flush = 1'b1;
    #1 chk("t4_stall_flush", stall, 1'b1);
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("t4_stall_after", stall, 1'b0);
    chk("t4_result_kept", result, 64'd81);
    for (int unsigned i = 0; i < LAT + 1; i++) begin
      @(negedge clk);
      #1 chk("t4_no_valid", result_valid, 1'b0);
    end
    launch(64'd5, 64'd6, 5'd4, 1'b0, "t4b");
    @(negedge clk);
    chk_done(64'd30, 5'd4, 1'b0, "t4b");

    // flush in DONE: current pulse still valid; flush+start in IDLE is dropped
    launch(64'd7, 64'd8, 5'd5, 1'b0, "tf");
    @(negedge clk);
    flush = 1'b1;
    chk_done(64'd56, 5'd5, 1'b0, "tf");
    @(negedge clk);
    start = 1'b1;
    op_a  = 64'd2;
    op_b  = 64'd3;
    #1 chk("tf_idle_valid", result_valid, 1'b0);
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    #1 chk("tf_start_dropped", stall, 1'b0);

    // 5: asynchronous reset in the middle of a multiply
    @(negedge clk);
    start = 1'b1;
    op_a  = 64'd4;
    op_b  = 64'd5;
    rd_in = 5'd8;
    for (int unsigned i = 0; i < 3; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    #1 arst_n = 1'b0;
    #1;
    chk("t5_stall", stall, 1'b0);
    chk("t5_result", result, 64'd0);
    chk("t5_valid", result_valid, 1'b0);
    chk("t5_rd", rd_out, 5'd0);
    @(negedge clk);
    arst_n = 1'b1;
    for (int unsigned i = 0; i < LAT + 1; i++) begin
      @(negedge clk);
      #1 chk("t5_no_valid", result_valid, 1'b0);
    end
    launch(64'd2, 64'd2, 5'd9, 1'b0, "t5b");
    @(negedge clk);
    chk_done(64'd4, 5'd9, 1'b0, "t5b");

`ifdef MULT_HIGH_EN
    // 6: 2^63 * 2^63 = 2^126 -> high half 2^62, low half 0
    hi_sel = 1'b1;
    launch(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 5'd10, 1'b0, "t6h");
    @(negedge clk);
    chk_done(64'h4000_0000_0000_0000, 5'd10, 1'b0, "t6h");
    hi_sel = 1'b0;
    launch(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 5'd11, 1'b0, "t6l");
    @(negedge clk);
    chk_done(64'd0, 5'd11, 1'b0, "t6l");
`endif

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
